// File: rtl/dircc_types_pkg.sv
// Shared types for the outbound header path: packet address layout, scheduler states
// and the arbitration mode codes.
package dircc_types_pkg;

    localparam int ADDR_PORT_WIDTH = 5;

    typedef struct packed {
        logic [31:0]                hw_addr;
        logic [31:0]                sw_addr;
        logic [ADDR_PORT_WIDTH-1:0] port;
        logic                       flag;
    } address_t;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_FIXED       = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_EMIT
    } sched_state_t;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Combinational port arbiter: lowest set request (FIXED) or first set request strictly
// above the pointer, wrapping (ROUND_ROBIN).
module dircc_rr_arbiter
    import dircc_types_pkg::*;
#(
    parameter int N    = 31,
    parameter int MODE = ARB_ROUND_ROBIN,
    parameter int PW   = 5
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          found
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (MODE == ARB_FIXED) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant = PW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Scan from the farthest offset down so the nearest one above ptr wins.
            for (int i = N; i >= 1; i--) begin
                idx = (int'(ptr) + i >= N) ? PW'(int'(ptr) + i - N) : PW'(int'(ptr) + i);
                if (req[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dircc_fanout_scheduler.sv
// Per-thread fan-out scheduler: expands one RTS batch into one stamped header per edge
// target, reading targets from an external table with one cycle read latency.
module dircc_fanout_scheduler
    import dircc_types_pkg::*;
#(
    parameter int    NUM_PORTS        = 31,
    parameter int    TARGET_IDX_WIDTH = 8,
    parameter int    LAMPORT_WIDTH    = 32,
    parameter string ARB_MODE         = "ROUND_ROBIN",
    localparam int   PORT_IDX_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 local_hw_addr,
    input  logic [31:0]                 local_sw_addr,
    input  logic                        rts_valid,
    output logic                        rts_ready,
    input  logic [NUM_PORTS-1:0]        rts_mask,
    input  logic [LAMPORT_WIDTH-1:0]    rts_lamport,
    output logic                        tbl_rd,
    output logic [PORT_IDX_WIDTH-1:0]   tbl_port,
    output logic [TARGET_IDX_WIDTH-1:0] tbl_index,
    input  logic [TARGET_IDX_WIDTH-1:0] tbl_num_targets,
    input  address_t                    tbl_target,
    output logic                        hdr_valid,
    input  logic                        hdr_ready,
    output address_t                    hdr_dest,
    output address_t                    hdr_src,
    output logic [LAMPORT_WIDTH-1:0]    hdr_lamport,
    output logic                        hdr_last,
    output logic                        busy,
    output logic [15:0]                 skip_count
);

    localparam int MODE = (ARB_MODE == "FIXED") ? ARB_FIXED : ARB_ROUND_ROBIN;
    localparam int TW   = TARGET_IDX_WIDTH + 1;

    sched_state_t                state, state_nx;
    logic [NUM_PORTS-1:0]        pending, rest;
    logic [LAMPORT_WIDTH-1:0]    lamport_q;
    logic [PORT_IDX_WIDTH-1:0]   rr_ptr, grant, grant_q;
    logic                        found;
    logic [TARGET_IDX_WIDTH-1:0] index_q;
    logic                        last_tgt_q, wait_last_tgt;

    dircc_rr_arbiter #(
        .N    (NUM_PORTS),
        .MODE (MODE),
        .PW   (PORT_IDX_WIDTH)
    ) u_arb (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (grant),
        .found (found)
    );

    // Ports still owed work once the port being served is finished.
    always_comb begin
        rest          = pending;
        rest[grant_q] = 1'b0;
    end

    assign wait_last_tgt = (({1'b0, index_q} + TW'(1)) == {1'b0, tbl_num_targets});
    assign rts_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign hdr_valid     = (state == S_EMIT);

    always_comb begin
        state_nx  = state;
        tbl_rd    = 1'b0;
        tbl_port  = grant_q;
        tbl_index = index_q;
        case (state)
            S_IDLE: begin
                if (rts_valid && (rts_mask != '0))
                    state_nx = S_SELECT;
            end
            S_SELECT: begin
                if (found) begin
                    tbl_rd    = 1'b1;
                    tbl_port  = grant;
                    tbl_index = '0;
                    state_nx  = S_WAIT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tbl_num_targets == '0)
                    state_nx = (rest != '0) ? S_SELECT : S_IDLE;
                else
                    state_nx = S_EMIT;
            end
            S_EMIT: begin
                if (hdr_ready) begin
                    if (last_tgt_q) begin
                        state_nx = (rest != '0) ? S_SELECT : S_IDLE;
                    end else begin
                        tbl_rd    = 1'b1;
                        tbl_index = index_q + TARGET_IDX_WIDTH'(1);
                        state_nx  = S_WAIT;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= '0;
            lamport_q   <= '0;
            rr_ptr      <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
            grant_q     <= '0;
            index_q     <= '0;
            last_tgt_q  <= 1'b0;
            hdr_dest    <= '0;
            hdr_src     <= '0;
            hdr_lamport <= '0;
            hdr_last    <= 1'b0;
            skip_count  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (rts_valid) begin
                        pending   <= rts_mask;
                        lamport_q <= rts_lamport;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        grant_q <= grant;
                        index_q <= '0;
                        rr_ptr  <= grant;
                    end
                end
                S_WAIT: begin
                    if (tbl_num_targets == '0) begin
                        pending <= rest;
                        if (skip_count != 16'hFFFF)
                            skip_count <= skip_count + 16'd1;
                    end else begin
                        hdr_dest         <= tbl_target;
                        hdr_src.hw_addr  <= local_hw_addr;
                        hdr_src.sw_addr  <= local_sw_addr;
                        hdr_src.port     <= ADDR_PORT_WIDTH'(grant_q);
                        hdr_src.flag     <= 1'b0;
                        hdr_lamport      <= lamport_q;
                        hdr_last         <= wait_last_tgt && (rest == '0);
                        last_tgt_q       <= wait_last_tgt;
                    end
                end
                S_EMIT: begin
                    if (hdr_ready) begin
                        if (last_tgt_q)
                            pending <= rest;
                        else
                            index_q <= index_q + TARGET_IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
